// File: rtl/mux4_rr_arbiter.sv
// Four-source round-robin arbiter with a registered data mux and a bounded
// grant hold time so one busy source cannot starve the others.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] REQ,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  output logic [3:0] GNT,
  output logic       S1,
  output logic       S0,
  output logic       Y,
  output logic       VALID,
  output logic       BUSY
);

  localparam logic [3:0] MAXH = 4'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] own_q, own_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] gnt_q, gnt_d;
  logic       y_q, y_d;
  logic       valid_q, valid_d;
  logic [3:0] din;
  logic [3:0] others;

  // First set bit at or after start, wrapping; caller guarantees req != 0.
  function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    pick = start;
    for (int unsigned i = 4; i > 0; i--) begin
      idx = start + 2'(i - 1);
      if (req[idx]) pick = idx;
    end
  endfunction

  assign din    = {D, C, B, A};
  assign others = REQ & ~(4'b0001 << own_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    y_d     = y_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|REQ) begin
          own_d   = pick(REQ, ptr_q);
          gnt_d   = 4'b0001 << own_d;
          hold_d  = 4'd1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (REQ[own_q]) begin
          y_d     = din[own_q];
          valid_d = 1'b1;
          if (hold_q >= MAXH) begin
            // Expiry only forces a handover when someone else is waiting.
            if (|others) begin
              ptr_d  = own_q + 2'd1;
              own_d  = pick(others, own_q + 2'd1);
              gnt_d  = 4'b0001 << own_d;
              hold_d = 4'd1;
            end
          end else begin
            hold_d = hold_q + 4'd1;
          end
        end else begin
          ptr_d = own_q + 2'd1;
          if (|REQ) begin
            own_d  = pick(REQ, own_q + 2'd1);
            gnt_d  = 4'b0001 << own_d;
            hold_d = 4'd1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign GNT   = gnt_q;
  assign S1    = own_q[1];
  assign S0    = own_q[0];
  assign Y     = y_q;
  assign VALID = valid_q;
  assign BUSY  = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: a vector table for the main flows plus
// short loops for rotation, saturation and the MAX_HOLD=1 corner.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt4, gnt1;
  logic       s1_4, s0_4, y4, v4, b4;
  logic       s1_1, s0_1, y1, v1, b1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
    .CLK(clk), .RST_N(rst_n), .REQ(req),
    .A(d[0]), .B(d[1]), .C(d[2]), .D(d[3]),
    .GNT(gnt4), .S1(s1_4), .S0(s0_4), .Y(y4), .VALID(v4), .BUSY(b4)
  );

  mux4_rr_arbiter #(.MAX_HOLD(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .REQ(req),
    .A(d[0]), .B(d[1]), .C(d[2]), .D(d[3]),
    .GNT(gnt1), .S1(s1_1), .S0(s0_1), .Y(y1), .VALID(v1), .BUSY(b1)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       y;
    logic       v;
    logic       b;
  } vec_t;

  vec_t vt[23];

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive inputs away from the edge, then sample 1 time unit after it.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] dd);
    rst_n = r;
    req   = rq;
    d     = dd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    d     = '0;
    #2;

    vt[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1};
    vt[3]  = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b1};
    vt[4]  = '{1'b1, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1};
    vt[5]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1};
    vt[8]  = '{1'b1, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b1};
    vt[9]  = '{1'b1, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b1, 4'b1001, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b0, 1'b1};
    vt[11] = '{1'b1, 4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1};
    vt[12] = '{1'b1, 4'b1001, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b1};
    vt[13] = '{1'b1, 4'b1001, 4'b0001, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b1};
    vt[14] = '{1'b1, 4'b1001, 4'b1000, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1};
    vt[15] = '{1'b1, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1};
    vt[16] = '{1'b1, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b1};
    vt[17] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    vt[18] = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b1};
    vt[19] = '{1'b1, 4'b1111, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1};
    vt[20] = '{1'b1, 4'b1111, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1};
    vt[21] = '{1'b1, 4'b1111, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1};
    vt[22] = '{1'b1, 4'b1111, 4'b0001, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1};

    for (int i = 0; i < 23; i++) begin
      step(vt[i].rst_n, vt[i].req, vt[i].d);
      chk("gnt",   i, {4'b0, gnt4},       {4'b0, vt[i].gnt});
      chk("sel",   i, {6'b0, s1_4, s0_4}, {6'b0, vt[i].s});
      chk("y",     i, {7'b0, y4},         {7'b0, vt[i].y});
      chk("valid", i, {7'b0, v4},         {7'b0, vt[i].v});
      chk("busy",  i, {7'b0, b4},         {7'b0, vt[i].b});
    end

    // Full-load rotation continues: B took over at the last table edge.
    for (int j = 1; j <= 12; j++) begin
      logic [1:0] o;
      o = 2'((1 + j / 4) % 4);
      step(1'b1, 4'b1111, 4'b0000);
      chk("rot_gnt",   j, {4'b0, gnt4},       {4'b0, 4'b0001 << o});
      chk("rot_sel",   j, {6'b0, s1_4, s0_4}, {6'b0, o});
      chk("rot_valid", j, {7'b0, v4},         8'd1);
    end

    // Lone requester C: hold saturates and the grant never drops.
    step(1'b0, 4'b0100, 4'b0000);
    for (int j = 1; j <= 25; j++) begin
      step(1'b1, 4'b0100, 4'b0100);
      chk("sat_gnt", j, {4'b0, gnt4},       8'h04);
      chk("sat_sel", j, {6'b0, s1_4, s0_4}, 8'd2);
    end
    // Saturated hold hands over immediately once A shows up.
    step(1'b1, 4'b0101, 4'b0000);
    chk("sat_handover_gnt",   0, {4'b0, gnt4}, 8'h01);
    chk("sat_handover_valid", 0, {7'b0, v4},   8'd1);
    chk("sat_handover_y",     0, {7'b0, y4},   8'd0);

    // MAX_HOLD=1 instance: A and B alternate every edge, data never stalls.
    step(1'b0, 4'b0011, 4'b0001);
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 4'b0011, 4'b0001);
      if (k == 1) begin
        chk("mh1_gnt",   k, {4'b0, gnt1}, 8'h01);
        chk("mh1_valid", k, {7'b0, v1},   8'd0);
      end else begin
        chk("mh1_gnt",   k, {4'b0, gnt1}, (k % 2 == 0) ? 8'h02 : 8'h01);
        chk("mh1_valid", k, {7'b0, v1},   8'd1);
        chk("mh1_y",     k, {7'b0, y1},   (k % 2 == 0) ? 8'd1 : 8'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, range 1..15: maximum consecutive grant cycles for one owner while any other requester is pending.
REQ-002 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 RST_N  input  1  reset, synchronous, active-low.
REQ-004 REQ  input  4  request per source; REQ[0]=A, REQ[1]=B, REQ[2]=C, REQ[3]=D.
REQ-005 A, B, C, D  input  1 each  source data bits.
REQ-006 GNT  output  4  one-hot grant, registered; all zero when no owner.
REQ-007 S1, S0  output  1 each  registered mux select; {S1,S0} = owner index (A=00, B=01, C=10, D=11).
REQ-008 Y  output  1  registered data of current owner.
REQ-009 VALID  output  1  registered; 1 when Y carries a newly transferred bit.
REQ-010 BUSY  output  1  1 while in state GRANT.

Function
REQ-011 The block SHALL have two states: IDLE (no owner) and GRANT (one owner, index OWN).
REQ-012 The block SHALL keep a 2-bit rotating pointer PTR; the search order SHALL be PTR, PTR+1, PTR+2, PTR+3 (mod 4), and the first set candidate wins.
REQ-013 IDLE with REQ != 0 at an edge: GNT, {S1,S0}, and OWN SHALL take the winner at that edge; state -> GRANT; HOLD counter -> 1.
REQ-014 IDLE with REQ == 0: GNT SHALL stay 0, {S1,S0} SHALL hold its last value, and VALID SHALL be 0.
REQ-015 GRANT with REQ[OWN]=1 at an edge: Y SHALL take the input selected by the current {S1,S0}, and VALID SHALL be 1 (one-cycle latency from data to Y).
REQ-016 GRANT with REQ[OWN]=0 at an edge (release): VALID SHALL be 0, Y SHALL hold, and PTR SHALL become OWN+1 (mod 4).
REQ-017 On release, if any REQ bit is set, the next owner SHALL be chosen by REQ-012 using the new PTR and granted at the same edge (zero-gap handover, HOLD=1); otherwise state -> IDLE and GNT -> 0.
REQ-018 Hold expiry: if in GRANT, HOLD == MAX_HOLD, REQ[OWN]=1, and any other REQ bit is set, then at that edge the current bit SHALL still transfer (VALID=1), PTR SHALL become OWN+1, and the grant SHALL hand over per REQ-012 with REQ[OWN] masked out (HOLD=1).
REQ-019 If HOLD == MAX_HOLD and no other request is pending, the owner SHALL keep the grant and HOLD SHALL stay at MAX_HOLD (saturate, no wrap).
REQ-020 Otherwise in GRANT, HOLD SHALL increment by 1 per edge.
REQ-021 GNT SHALL always be zero or one-hot, and SHALL be consistent with {S1,S0} whenever it is nonzero.
REQ-022 REQ bits of non-owners SHALL NOT affect Y or VALID.

Reset
REQ-023 When RST_N=0 at an edge: GNT=0, S1=S0=0, Y=0, VALID=0, BUSY=0, PTR=0, HOLD=0, and state=IDLE, regardless of prior state (including mid-grant).
REQ-024 REQ SHALL be ignored during reset; arbitration SHALL begin at the first edge with RST_N=1.

Verification
REQ-025 After reset, REQ=0001 with A toggling 1,0,1: GNT=0001 and S1S0=00 after edge 1; Y=1,0,1 with VALID=1 on edges 2-4.
REQ-026 REQ=1111 held, MAX_HOLD=4: owners A,B,C,D,A... each hold GNT for exactly 4 edges, with no GNT=0 cycle between them.
REQ-027 After reset, REQ=0100 only: grant C with S1S0=10; HOLD saturates and GNT stays 0100 for 20+ cycles.
REQ-028 Owner B, REQ drops to 0000: VALID=0 at that edge, GNT=0 and BUSY=0, PTR=2; a later REQ=1001 grants D first.
REQ-029 Mid-grant with GNT=1000, assert RST_N=0 for one edge: all outputs are 0 at that edge; after release, REQ=1111 grants A first.
REQ-030 MAX_HOLD=1 with REQ=0011: GNT alternates 0001/0010 every edge and VALID=1 continuously.
